// File: rtl/ysyx_22050550_mul_ctrl_pkg.sv
// Shared types and helpers for the multiply issue/writeback controller.
package ysyx_22050550_mul_ctrl_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned OP_W = 3;
   localparam int unsigned RD_W = 5;

   typedef enum logic [OP_W-1:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_MULW   = 3'd4
   } mul_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   // {src1_signed, src2_signed}
   localparam logic [1:0] SGN_SS = 2'b11;
   localparam logic [1:0] SGN_SU = 2'b10;
   localparam logic [1:0] SGN_UU = 2'b00;

   typedef struct packed {
      mul_op_e             op;
      logic [XLEN-1:0]     src1;
      logic [XLEN-1:0]     src2;
      logic [RD_W-1:0]     rd;
   } mul_req_t;

   // Operand signedness presented to the multiplier
   function automatic logic [1:0] signed_mode(input mul_op_e op);
      case (op)
         OP_MULHSU: return SGN_SU;
         OP_MULHU:  return SGN_UU;
         default:   return SGN_SS;
      endcase
   endfunction

   // Product is known to be zero without running the multiplier
   function automatic logic is_zero_op(input mul_op_e op,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
      logic z;
      z = (a == '0) || (b == '0);
      if (op == OP_MULW)
         z = z || (a[31:0] == 32'd0) || (b[31:0] == 32'd0);
      return z;
   endfunction

endpackage

// File: rtl/ysyx_22050550_mul_fmt.sv
// Selects and formats the architectural result from the raw product halves.
module ysyx_22050550_mul_fmt
   import ysyx_22050550_mul_ctrl_pkg::*;
(
   input  mul_op_e          op,
   input  logic [XLEN-1:0]  res_h,
   input  logic [XLEN-1:0]  res_l,
   output logic [XLEN-1:0]  result_c
);

   // High half for MULH*, sign-extended low word for MULW, low half otherwise
   always_comb begin
      result_c = res_l;
      case (op)
         OP_MULH, OP_MULHSU, OP_MULHU: result_c = res_h;
         OP_MULW:                      result_c = {{32{res_l[31]}}, res_l[31:0]};
         default:                      result_c = res_l;
      endcase
   end

endmodule

// File: rtl/ysyx_22050550_mul_ctrl.sv
// Issue/writeback controller between the EXU and the radix-4 Booth multiplier.
module ysyx_22050550_mul_ctrl
   import ysyx_22050550_mul_ctrl_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_op,
   input  logic [63:0]   in_src1,
   input  logic [63:0]   in_src2,
   input  logic [4:0]    in_rd,
   input  logic          flush,
   output logic          mul_valid,
   output logic          mul_w,
   output logic [1:0]    mul_signed,
   output logic [63:0]   mul_a,
   output logic [63:0]   mul_b,
   input  logic          mul_ready,
   input  logic          mul_out_valid,
   input  logic [63:0]   mul_res_h,
   input  logic [63:0]   mul_res_l,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [63:0]   out_result,
   output logic [4:0]    out_rd
);

   state_e          state_q, state_d;
   mul_req_t        req_q;
   logic [XLEN-1:0] result_q;
   logic [XLEN-1:0] fmt_result;
   mul_op_e         in_op_e;
   logic            accept;
   logic            zero_op;

   assign in_op_e  = mul_op_e'(in_op);
   assign in_ready = (state_q == IDLE) && mul_ready && !flush;
   assign accept   = in_valid && in_ready;
   assign zero_op  = is_zero_op(in_op_e, in_src1, in_src2);

   // Multiplier side is driven purely from state and latched operands
   assign mul_valid  = (state_q == BUSY) || (state_q == DRAIN);
   assign mul_w      = (req_q.op == OP_MULW);
   assign mul_signed = signed_mode(req_q.op);
   assign mul_a      = req_q.src1;
   assign mul_b      = req_q.src2;

   // A flush kills a pending result combinationally so no transfer can occur
   assign out_valid  = (state_q == DONE) && !flush;
   assign out_result = result_q;
   assign out_rd     = req_q.rd;

   ysyx_22050550_mul_fmt u_fmt (
      .op       (req_q.op),
      .res_h    (mul_res_h),
      .res_l    (mul_res_l),
      .result_c (fmt_result)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; BUSY/DRAIN hold mul_valid until the multiplier reports done
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = zero_op ? DONE : BUSY;
         end
         BUSY: begin
            if (flush)              state_d = mul_out_valid ? IDLE : DRAIN;
            else if (mul_out_valid) state_d = DONE;
         end
         DONE: begin
            if (flush || out_ready) state_d = IDLE;
         end
         DRAIN: begin
            if (mul_out_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request latch on accept; result captured on zero bypass or multiplier completion
   always_ff @(posedge clock) begin
      if (reset) begin
         req_q    <= '0;
         result_q <= '0;
      end else begin
         if (accept) begin
            req_q <= '{op: in_op_e, src1: in_src1, src2: in_src2, rd: in_rd};
            if (zero_op) result_q <= '0;
         end else if ((state_q == BUSY) && mul_out_valid && !flush) begin
            result_q <= fmt_result;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22050550_mul_ctrl.sv
// Self-checking bench for ysyx_22050550_mul_ctrl with a behavioural Booth multiplier.
module tb_ysyx_22050550_mul_ctrl;

   localparam logic [2:0] T_MUL = 3'd0, T_MULH = 3'd1, T_MULHSU = 3'd2,
                          T_MULHU = 3'd3, T_MULW = 3'd4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_op = 3'd0;
   logic [63:0] in_src1 = 64'd0, in_src2 = 64'd0;
   logic [4:0]  in_rd = 5'd0;
   logic        flush = 1'b0;
   logic        mul_valid, mul_w;
   logic [1:0]  mul_signed;
   logic [63:0] mul_a, mul_b;
   logic        mul_ready;
   logic        mul_out_valid;
   logic [63:0] mul_res_h, mul_res_l;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_result;
   logic [4:0]  out_rd;

   int n_vec = 0;
   int n_err = 0;

   typedef struct { logic [63:0] res; logic [4:0] rd; } exp_t;
   exp_t sb[$];

   ysyx_22050550_mul_ctrl dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd), .flush(flush),
      .mul_valid(mul_valid), .mul_w(mul_w), .mul_signed(mul_signed),
      .mul_a(mul_a), .mul_b(mul_b), .mul_ready(mul_ready),
      .mul_out_valid(mul_out_valid), .mul_res_h(mul_res_h), .mul_res_l(mul_res_l),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_rd(out_rd)
   );

   always #5 clock = ~clock;

   // Behavioural multiplier: Idle -> Busy (16/32 cycles) -> one-cycle output pulse
   int          mst = 0;
   int          mcnt = 0;
   logic        mov = 1'b0;
   logic [63:0] mh = 64'd0, ml = 64'd0;
   assign mul_ready     = (mst == 0);
   assign mul_out_valid = mov;
   assign mul_res_h     = mh;
   assign mul_res_l     = ml;

   function automatic logic [127:0] prod(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] sg, input logic w);
      logic [63:0]  aa, bb;
      logic [127:0] ea, eb;
      aa = a; bb = b;
      if (w) begin
         aa = {{32{a[31]}}, a[31:0]};
         bb = {{32{b[31]}}, b[31:0]};
      end
      ea = sg[1] ? {{64{aa[63]}}, aa} : {64'd0, aa};
      eb = sg[0] ? {{64{bb[63]}}, bb} : {64'd0, bb};
      return ea * eb;
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         mst <= 0; mcnt <= 0; mov <= 1'b0; mh <= 64'd0; ml <= 64'd0;
      end else begin
         case (mst)
            0: if (mul_valid) begin mst <= 1; mcnt <= mul_w ? 16 : 32; end
            1: if (mul_valid) begin
                  if (mcnt == 1) begin
                     mst <= 2; mov <= 1'b1;
                     {mh, ml} <= prod(mul_a, mul_b, mul_signed, mul_w);
                  end else mcnt <= mcnt - 1;
               end
            default: begin mov <= 1'b0; if (mul_valid) mst <= 0; end
         endcase
      end
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: got running, want finished");
      $fatal(1, "timeout");
   end

   // Present one op and wait (bounded) for the accepting edge
   task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input logic [63:0] exp, input bit push,
                        output bit ok);
      if (push) sb.push_back('{exp, rd});
      @(negedge clock);
      in_op = op; in_src1 = a; in_src2 = b; in_rd = rd; in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (in_ready) begin ok = 1'b1; break; end
         @(negedge clock);
      end
      @(posedge clock);
      #1 in_valid = 1'b0;
   endtask

   // Count cycles after accept until out_valid; watch multiplier-side controls
   task automatic wait_out(input logic [63:0] a, input logic [63:0] b, input logic w,
                           input logic [1:0] sg, output int lat, output bit saw_mv,
                           output bit ctl_bad);
      lat = -1; saw_mv = 1'b0; ctl_bad = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clock);
         if (mul_valid) begin
            saw_mv = 1'b1;
            if (mul_w !== w || mul_signed !== sg || mul_a !== a || mul_b !== b) ctl_bad = 1'b1;
         end
         if (out_valid) begin lat = n; break; end
      end
   endtask

   // Sample the presented result, pop its expectation, and let the transfer edge pass
   task automatic take_out(output exp_t e, output bit have, output logic [63:0] res,
                           output logic [4:0] rd);
      res = out_result; rd = out_rd;
      have = (sb.size() > 0);
      if (have) e = sb.pop_front();
      else e = '{64'd0, 5'd0};
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_vec++; if (mul_valid !== 1'b0) begin n_err++; $display("FAIL rst_mul_valid: got %b want 0", mul_valid); end
      n_vec++; if (out_result !== 64'd0) begin n_err++; $display("FAIL rst_out_result: got %h want 0", out_result); end
      n_vec++; if (out_rd !== 5'd0) begin n_err++; $display("FAIL rst_out_rd: got %h want 0", out_rd); end
      n_vec++; if (mul_a !== 64'd0 || mul_b !== 64'd0) begin n_err++; $display("FAIL rst_mul_ab: got %h/%h want 0/0", mul_a, mul_b); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      reset = 1'b0;
   endtask

   // One scoreboarded op with latency, control and post-transfer ready checks
   task automatic test_op(input string name, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp,
                          input int exp_lat, input logic w, input logic [1:0] sg);
      bit ok, saw, bad, have; int lat; exp_t e; logic [63:0] res; logic [4:0] ord;
      issue(op, a, b, rd, exp, 1'b1, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL %s_accept: got no accept want accept", name); end
      wait_out(a, b, w, sg, lat, saw, bad);
      n_vec++; if (lat != exp_lat) begin n_err++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat); end
      n_vec++; if (saw !== (exp_lat != 1)) begin n_err++; $display("FAIL %s_mul_valid_seen: got %b want %b", name, saw, exp_lat != 1); end
      n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL %s_mul_ctl: got unstable/wrong w/signed/a/b want w=%b signed=%b", name, w, sg); end
      take_out(e, have, res, ord);
      n_vec++; if (!have || res !== e.res) begin n_err++; $display("FAIL %s_result: got %h want %h", name, res, e.res); end
      n_vec++; if (ord !== e.rd) begin n_err++; $display("FAIL %s_rd: got %h want %h", name, ord, e.rd); end
      @(negedge clock);
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL %s_after_xfer: got in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid); end
   endtask

   task automatic test_mul();
      test_op("mul_3x5", T_MUL, 64'd3, 64'd5, 5'd9, 64'h000000000000000F, 35, 1'b0, 2'b11);
   endtask

   task automatic test_mulw();
      test_op("mulw", T_MULW, 64'h7FFFFFFF, 64'd2, 5'd17, 64'hFFFFFFFFFFFFFFFE, 19, 1'b1, 2'b11);
   endtask

   task automatic test_signedness();
      logic [2:0]  ops [3] = '{T_MULHU, T_MULH, T_MUL};
      logic [63:0] as  [3] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
      logic [63:0] bs  [3] = '{64'd2, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
      logic [63:0] ex  [3] = '{64'd1, 64'd0, 64'd1};
      logic [1:0]  sgs [3] = '{2'b00, 2'b11, 2'b11};
      for (int i = 0; i < 3; i++)
         test_op("signed_tbl", ops[i], as[i], bs[i], 5'(i + 1), ex[i], 35, 1'b0, sgs[i]);
      test_op("mulhsu", T_MULHSU, 64'hFFFFFFFFFFFFFFFF, 64'd2, 5'd4, 64'hFFFFFFFFFFFFFFFF, 35, 1'b0, 2'b10);
   endtask

   task automatic test_zero();
      test_op("zero_mulh", T_MULH, 64'd0, 64'h1234, 5'd3, 64'd0, 1, 1'b0, 2'b11);
      test_op("zero_mulw_lo", T_MULW, 64'h1_0000_0000, 64'd5, 5'd6, 64'd0, 1, 1'b1, 2'b11);
      test_op("nonzero_mul_hi", T_MUL, 64'h1_0000_0000, 64'd3, 5'd7, 64'h3_0000_0000, 35, 1'b0, 2'b11);
   endtask

   task automatic test_flush();
      bit ok, drain_bad, ov_seen, rdy35; int mov_n;
      // flush in IDLE blocks accept
      @(negedge clock);
      in_op = T_MUL; in_src1 = 64'd2; in_src2 = 64'd2; in_rd = 5'd1;
      in_valid = 1'b1; flush = 1'b1;
      drain_bad = 1'b0;
      repeat (3) begin @(negedge clock); if (in_ready !== 1'b0) drain_bad = 1'b1; end
      in_valid = 1'b0; flush = 1'b0;
      n_vec++; if (drain_bad) begin n_err++; $display("FAIL flush_idle_ready: got in_ready=1 want 0"); end
      @(negedge clock);
      n_vec++; if (mul_valid !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_idle_accept: got mul_valid=%b out_valid=%b want 0/0", mul_valid, out_valid); end

      // flush in BUSY at T+10 -> DRAIN
      issue(T_MUL, 64'd5, 64'd5, 5'd2, 64'd25, 1'b0, ok);
      drain_bad = 1'b0; ov_seen = 1'b0; rdy35 = 1'b0; mov_n = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (out_valid) ov_seen = 1'b1;
         if (mul_out_valid && mov_n < 0) mov_n = n;
         if (n >= 11 && n <= 34 && (in_ready || !mul_valid)) drain_bad = 1'b1;
         if (n == 35) rdy35 = in_ready;
         if (n == 10) begin flush = 1'b1; @(posedge clock); #1 flush = 1'b0; end
      end
      n_vec++; if (drain_bad) begin n_err++; $display("FAIL drain_hold: got in_ready=1 or mul_valid=0 want 0/1"); end
      n_vec++; if (mov_n != 34) begin n_err++; $display("FAIL drain_mul_done: got cycle %0d want 34", mov_n); end
      n_vec++; if (ov_seen) begin n_err++; $display("FAIL drain_out_valid: got 1 want 0"); end
      n_vec++; if (rdy35 !== 1'b1) begin n_err++; $display("FAIL drain_ready35: got %b want 1", rdy35); end
      test_op("post_flush_7x6", T_MUL, 64'd7, 64'd6, 5'd11, 64'd42, 35, 1'b0, 2'b11);

      // flush in BUSY coinciding with mul_out_valid -> straight to IDLE
      issue(T_MUL, 64'd3, 64'd3, 5'd2, 64'd9, 1'b0, ok);
      repeat (34) @(negedge clock);
      n_vec++; if (mul_out_valid !== 1'b1) begin n_err++; $display("FAIL flush_edge_mov: got %b want 1", mul_out_valid); end
      flush = 1'b1; @(posedge clock); #1 flush = 1'b0;
      @(negedge clock);
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || mul_valid !== 1'b0) begin n_err++; $display("FAIL flush_edge_idle: got in_ready=%b out_valid=%b mul_valid=%b want 1/0/0", in_ready, out_valid, mul_valid); end

      // flush in DONE masks out_valid and returns to IDLE
      out_ready = 1'b0;
      issue(T_MUL, 64'd0, 64'd9, 5'd2, 64'd0, 1'b0, ok);
      @(negedge clock);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_done_pre: got %b want 1", out_valid); end
      flush = 1'b1; #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_done_mask: got %b want 0", out_valid); end
      @(posedge clock); #1 flush = 1'b0; out_ready = 1'b1;
      @(negedge clock);
      n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_done_idle: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
   endtask

   task automatic test_backpressure();
      bit ok, saw, bad, have, hold_bad; int lat; exp_t e; logic [63:0] res; logic [4:0] ord;
      out_ready = 1'b0;
      issue(T_MUL, 64'h10, 64'h10, 5'd21, 64'h100, 1'b1, ok);
      wait_out(64'h10, 64'h10, 1'b0, 2'b11, lat, saw, bad);
      n_vec++; if (lat != 35) begin n_err++; $display("FAIL bp_latency: got %0d want 35", lat); end
      hold_bad = 1'b0;
      repeat (5) begin
         @(negedge clock);
         if (out_valid !== 1'b1 || out_result !== 64'h100 || out_rd !== 5'd21) hold_bad = 1'b1;
      end
      n_vec++; if (hold_bad) begin n_err++; $display("FAIL bp_hold: got unstable out_valid/result/rd want 1/100/15"); end
      out_ready = 1'b1;
      take_out(e, have, res, ord);
      n_vec++; if (!have || res !== e.res || ord !== e.rd) begin n_err++; $display("FAIL bp_result: got %h/%h want %h/%h", res, ord, e.res, e.rd); end
      @(negedge clock);
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_after_xfer: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
   endtask

   task automatic test_reset_midop();
      bit ok;
      issue(T_MUL, 64'd9, 64'd9, 5'd30, 64'd81, 1'b0, ok);
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      n_vec++; if (mul_valid !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valids: got mul_valid=%b out_valid=%b want 0/0", mul_valid, out_valid); end
      n_vec++; if (mul_a !== 64'd0 || mul_b !== 64'd0 || out_rd !== 5'd0 || out_result !== 64'd0) begin n_err++; $display("FAIL midrst_regs: got a=%h b=%h rd=%h res=%h want zeros", mul_a, mul_b, out_rd, out_result); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
      reset = 1'b0;
      test_op("post_rst_mul", T_MUL, 64'd4, 64'd4, 5'd5, 64'd16, 35, 1'b0, 2'b11);
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulw();
      test_signedness();
      test_zero();
      test_flush();
      test_backpressure();
      test_reset_midop();
      n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
